// File: rtl/uart_tx.sv
// UART transmitter that pops bytes from a FIFO and serialises them.
// One start bit, eight data bits LSB first, one or two stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       TX_EN_I,
  input  logic       FIFO_EMPTY_I,
  input  logic [7:0] FIFO_DATA_I,
  output logic       FIFO_RE_O,
  output logic       TX_O,
  output logic       BUSY_O
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_n;
  logic          r_stop;
  logic          w_stop_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic          r_tx;
  logic          w_tx_n;

  logic w_bit_end;
  logic w_last_stop;
  logic w_frame_end;
  logic w_can_pop;
  logic w_pop;

  assign w_bit_end   = (r_cnt == LAST);
  assign w_last_stop = (STOP_BITS == 1) || r_stop;
  assign w_frame_end = (r_state == STOP)
                     && w_bit_end && w_last_stop;
  assign w_can_pop   = TX_EN_I && !FIFO_EMPTY_I;
  assign w_pop       = w_can_pop
                     && ((r_state == IDLE) || w_frame_end);

  // Pop strobe is held off while reset is asserted,
  // even though the idle state would otherwise allow it.
  assign FIFO_RE_O = w_pop && RST_NI;
  assign TX_O      = r_tx;
  assign BUSY_O    = (r_state != IDLE);

  // State and datapath registers.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_stop  <= w_stop_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

  // Next-state, bit timing and serial line value.
  // TX is computed one cycle ahead so the line
  // changes on the same edge as the state.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_stop_n  = r_stop;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    unique case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        w_tx_n  = 1'b1;
        if (w_pop) begin
          w_state_n = START;
          w_shift_n = FIFO_DATA_I;
          w_tx_n    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_n = DATA;
          w_tx_n    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_n = r_shift >> 1;
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_n = STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_tx_n = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (w_last_stop) begin
            w_stop_n = 1'b0;
            if (w_pop) begin
              w_state_n = START;
              w_shift_n = FIFO_DATA_I;
              w_tx_n    = 1'b0;
            end else begin
              w_state_n = IDLE;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_stop_n = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one S=1 and one S=2 instance,
// both with four clocks per bit.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       en, empty;
  logic [7:0] data;
  logic       re, tx, busy;

  logic       en2, empty2;
  logic [7:0] data2;
  logic       re2, tx2, busy2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
    .TX_EN_I     (en),
    .FIFO_EMPTY_I(empty),
    .FIFO_DATA_I (data),
    .FIFO_RE_O   (re),
    .TX_O        (tx),
    .BUSY_O      (busy)
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
    .TX_EN_I     (en2),
    .FIFO_EMPTY_I(empty2),
    .FIFO_DATA_I (data2),
    .FIFO_RE_O   (re2),
    .TX_O        (tx2),
    .BUSY_O      (busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] expand(
    input logic [15:0] f, input int nb);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 4; c++)
        v[b*4+c] = f[b];
    return v;
  endfunction

  task automatic capture(
    input  bit           sel,
    input  int           n,
    input  int           drop,
    output logic [127:0] v,
    output int           nb,
    output int           nre,
    output int           at);
    logic t, b, r;
    v = '0; nb = 0; nre = 0; at = -1;
    for (int k = 0; k < n; k++) begin
      if (k == drop) begin
        if (sel) en2 = 1'b0;
        else en = 1'b0;
        #1;
      end
      t = sel ? tx2 : tx;
      b = sel ? busy2 : busy;
      r = sel ? re2 : re;
      v[k] = t;
      if (b === 1'b1) nb++;
      if (r === 1'b1) begin
        nre++;
        at = k;
      end
      step();
      if (r === 1'b1) begin
        if (sel) empty2 = 1'b1;
        else empty = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    en = 1'b1; empty = 1'b0; data = 8'hA5;
    en2 = 1'b1; empty2 = 1'b0; data2 = 8'h81;
    #1;
    n_total++;
    if (tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (re !== 1'b0) $display("FAIL rst_re: got %b want 0", re);
    else n_pass++;
    n_total++;
    if (tx2 !== 1'b1) $display("FAIL rst_tx2: got %b want 1", tx2);
    else n_pass++;
    n_total++;
    if (busy2 !== 1'b0) $display("FAIL rst_busy2: got %b want 0", busy2);
    else n_pass++;
    n_total++;
    if (re2 !== 1'b0) $display("FAIL rst_re2: got %b want 0", re2);
    else n_pass++;
    step();
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_clk_busy: got %b want 0", busy);
    else n_pass++;
    empty = 1'b1;
    empty2 = 1'b1;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (re !== 1'b0) $display("FAIL rel_empty_re: got %b want 0", re);
    else n_pass++;
    step();
  endtask

  task automatic test_single();
    logic [127:0] v, exp;
    int nb, nre, at;
    en = 1'b1; data = 8'hA5; empty = 1'b0;
    #1;
    n_total++;
    if (re !== 1'b1) $display("FAIL single_pop: got %b want 1", re);
    else n_pass++;
    step();
    empty = 1'b1; data = 8'h3C;
    capture(1'b0, 40, -1, v, nb, nre, at);
    exp = expand({6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    n_total++;
    if (v !== exp) $display("FAIL single_frame: got %h want %h", v, exp);
    else n_pass++;
    n_total++;
    if (nb != 40) $display("FAIL single_busy: got %0d want 40", nb);
    else n_pass++;
    n_total++;
    if (nre != 0) $display("FAIL single_extra_pop: got %0d want 0", nre);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (tx !== 1'b1) $display("FAIL single_idle_tx: got %b want 1", tx);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] v, exp;
    int nb, nre, at;
    en = 1'b1; data = 8'h00; empty = 1'b0;
    #1;
    n_total++;
    if (re !== 1'b1) $display("FAIL b2b_pop1: got %b want 1", re);
    else n_pass++;
    step();
    data = 8'hFF;
    capture(1'b0, 80, -1, v, nb, nre, at);
    exp = expand({6'd0, 1'b1, 8'h00, 1'b0}, 10)
        | (expand({6'd0, 1'b1, 8'hFF, 1'b0}, 10) << 40);
    n_total++;
    if (at != 39) $display("FAIL b2b_pop2_at: got %0d want 39", at);
    else n_pass++;
    n_total++;
    if (nre != 1) $display("FAIL b2b_pops: got %0d want 1", nre);
    else n_pass++;
    n_total++;
    if (v !== exp) $display("FAIL b2b_frames: got %h want %h", v, exp);
    else n_pass++;
    n_total++;
    if (nb != 80) $display("FAIL b2b_busy: got %0d want 80", nb);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_enable();
    logic [127:0] v, exp, ones;
    int nb, nre, at;
    en = 1'b0; data = 8'h55; empty = 1'b0;
    #1;
    capture(1'b0, 100, -1, v, nb, nre, at);
    ones = '0;
    for (int i = 0; i < 100; i++) ones[i] = 1'b1;
    n_total++;
    if (nre != 0) $display("FAIL en_off_pops: got %0d want 0", nre);
    else n_pass++;
    n_total++;
    if (nb != 0) $display("FAIL en_off_busy: got %0d want 0", nb);
    else n_pass++;
    n_total++;
    if (v !== ones) $display("FAIL en_off_tx: got %h want %h", v, ones);
    else n_pass++;
    en = 1'b1; data = 8'h3C; empty = 1'b0;
    #1;
    n_total++;
    if (re !== 1'b1) $display("FAIL en_pop: got %b want 1", re);
    else n_pass++;
    step();
    data = 8'h5A;
    capture(1'b0, 60, 17, v, nb, nre, at);
    ones = '0;
    for (int i = 40; i < 60; i++) ones[i] = 1'b1;
    exp = expand({6'd0, 1'b1, 8'h3C, 1'b0}, 10) | ones;
    n_total++;
    if (v !== exp) $display("FAIL en_drop_frame: got %h want %h", v, exp);
    else n_pass++;
    n_total++;
    if (nre != 0) $display("FAIL en_drop_pops: got %0d want 0", nre);
    else n_pass++;
    n_total++;
    if (nb != 40) $display("FAIL en_drop_busy: got %0d want 40", nb);
    else n_pass++;
    empty = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] v, exp;
    int nb, nre, at;
    en = 1'b1; data = 8'hC3; empty = 1'b0;
    #1;
    n_total++;
    if (re !== 1'b1) $display("FAIL rm_pop: got %b want 1", re);
    else n_pass++;
    step();
    data = 8'h96;
    for (int i = 0; i < 25; i++) step();
    n_total++;
    if (tx !== 1'b0) $display("FAIL rm_bit5: got %b want 0", tx);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (tx !== 1'b1) $display("FAIL rm_tx: got %b want 1", tx);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (re !== 1'b0) $display("FAIL rm_re: got %b want 0", re);
    else n_pass++;
    step();
    rst_n = 1'b1;
    #1;
    n_total++;
    if (re !== 1'b1) $display("FAIL rm_rel_pop: got %b want 1", re);
    else n_pass++;
    step();
    empty = 1'b1;
    capture(1'b0, 40, -1, v, nb, nre, at);
    exp = expand({6'd0, 1'b1, 8'h96, 1'b0}, 10);
    n_total++;
    if (v !== exp) $display("FAIL rm_frame: got %h want %h", v, exp);
    else n_pass++;
    n_total++;
    if (nb != 40) $display("FAIL rm_busy_len: got %0d want 40", nb);
    else n_pass++;
  endtask

  task automatic test_stop2();
    logic [127:0] v, exp;
    int nb, nre, at;
    en2 = 1'b1; data2 = 8'h81; empty2 = 1'b0;
    #1;
    n_total++;
    if (re2 !== 1'b1) $display("FAIL s2_pop: got %b want 1", re2);
    else n_pass++;
    step();
    empty2 = 1'b1;
    capture(1'b1, 44, -1, v, nb, nre, at);
    exp = expand({5'd0, 2'b11, 8'h81, 1'b0}, 11);
    n_total++;
    if (v !== exp) $display("FAIL s2_frame: got %h want %h", v, exp);
    else n_pass++;
    n_total++;
    if (v[43:36] !== 8'hFF) $display("FAIL s2_tail: got %h want ff", v[43:36]);
    else n_pass++;
    n_total++;
    if (nb != 44) $display("FAIL s2_busy: got %0d want 44", nb);
    else n_pass++;
    n_total++;
    if (busy2 !== 1'b0) $display("FAIL s2_idle: got %b want 0", busy2);
    else n_pass++;
    n_total++;
    if (tx2 !== 1'b1) $display("FAIL s2_idle_tx: got %b want 1", tx2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_stop2();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
